branch_history_table: RTL and testbench

Branch history table for the pipelined RISC-V core. It holds an array of 2-bit saturating counters, indexed by fetch PC, and returns a taken/not-taken prediction to the F-stage PC-select logic. It carries the lookup index and prediction through D and E alongside the instruction. In E it updates the selected counter with the resolved outcome and flags mispredictions to the hazard unit.

---
 rtl/branch_history_table_pkg.sv | 38 +++
 rtl/branch_history_table_local_predictor.sv | 45 ++++
 rtl/branch_history_table.sv | 153 +++++++++++++++
 tb/tb_branch_history_table.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_history_table_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_history_table_pkg
//  Purpose  : Shared types and constants for the branch history table:
//             2-bit saturating counter encodings, the counter-state type,
//             default table geometry and the counter next-state helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package branch_history_table_pkg;

  // Counter encodings; the MSB doubles as the taken/not-taken prediction.
  typedef enum logic [1:0] {
    CTR_SU = 2'b00,  // strongly not-taken
    CTR_WU = 2'b01,  // weakly not-taken (reset state)
    CTR_WT = 2'b10,  // weakly taken
    CTR_ST = 2'b11   // strongly taken
  } ctr_state_e;

  localparam int unsigned c_entries_log2_default = 6;
  localparam int unsigned c_ghr_width_default    = 6;

  // Move one step toward the resolved outcome, saturating at both ends.
  function automatic ctr_state_e ctr_next(input ctr_state_e cur, input logic taken);
    ctr_state_e nxt;
    nxt = cur;
    case (cur)
      CTR_SU:  nxt = taken ? CTR_WU : CTR_SU;
      CTR_WU:  nxt = taken ? CTR_WT : CTR_SU;
      CTR_WT:  nxt = taken ? CTR_ST : CTR_WU;
      CTR_ST:  nxt = taken ? CTR_ST : CTR_WT;
      default: nxt = CTR_WU;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_history_table_local_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : local_predictor
//  Purpose  : One 2-bit saturating counter of the branch history table.
//             Moves toward the resolved outcome on an enabled clock edge and
//             exposes its MSB as the prediction.
//  Ports    : clk_i          - clock
//             reset_i        - asynchronous active-high reset (counter -> WU)
//             enable_i       - update this counter on the current edge
//             pc_src_res_e_i - resolved outcome (1 = taken)
//             pc_src_pred_o  - current prediction (counter MSB)
//  Revision : 1.0 - initial release
// ============================================================================
module local_predictor
  import branch_history_table_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic pc_src_res_e_i,
  output logic pc_src_pred_o
);

  ctr_state_e state_q;
  ctr_state_e state_d;

  always_comb begin
    state_d = state_q;
    if (enable_i) begin
      state_d = ctr_next(state_q, pc_src_res_e_i);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= CTR_WU;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_src_pred_o = state_q[1];

endmodule
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module   : branch_history_table
//  Purpose  : Branch history table of 2-bit saturating counters indexed by
//             fetch PC. Predicts in F (combinational read, no bypass),
//             carries index/prediction through D and E, trains the selected
//             counter in E and flags mispredictions.
//  Config   : BHT_GSHARE_EN - when defined, a non-speculative global history
//             register is XORed into the index and shifts on every update.
//  Ports    : clk_i           - clock
//             reset_i         - asynchronous active-high reset
//             pc_f_i          - fetch PC
//             pc_src_pred_f_o - F-stage prediction
//             stall_d_i       - hold F->D tracking register
//             flush_d_i       - clear F->D tracking register
//             flush_e_i       - clear D->E tracking register
//             branch_op_e_i   - E-stage instruction is a conditional branch
//             pc_src_res_e_i  - resolved E-stage outcome (1 = taken)
//             pc_src_pred_e_o - prediction made for the E-stage instruction
//             mispredict_e_o  - E-stage branch prediction was wrong
//  Revision : 1.0 - initial release
// ============================================================================
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int unsigned ENTRIES_LOG2 = c_entries_log2_default,
  parameter int unsigned GHR_WIDTH    = c_ghr_width_default
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_f_i,
  output logic        pc_src_pred_f_o,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic        flush_e_i,
  input  logic        branch_op_e_i,
  input  logic        pc_src_res_e_i,
  output logic        pc_src_pred_e_o,
  output logic        mispredict_e_o
);

  localparam int unsigned c_entries = 2 ** ENTRIES_LOG2;

  logic [ENTRIES_LOG2-1:0] w_pc_idx;
  logic [ENTRIES_LOG2-1:0] w_idx_f;
  logic [c_entries-1:0]    w_pred_vec;
  logic [c_entries-1:0]    w_enable;
  logic                    w_unused_pc;

  // Tracking registers: F->D (fd_*) and D->E (de_*).
  logic [ENTRIES_LOG2-1:0] fd_idx_q, fd_idx_d;
  logic                    fd_pred_q, fd_pred_d;
  logic [ENTRIES_LOG2-1:0] de_idx_q, de_idx_d;
  logic                    de_pred_q, de_pred_d;

  assign w_pc_idx    = pc_f_i[ENTRIES_LOG2+1:2];
  assign w_unused_pc = ^{pc_f_i[31:ENTRIES_LOG2+2], pc_f_i[1:0]};

`ifdef BHT_GSHARE_EN
  logic [GHR_WIDTH-1:0]    ghr_q, ghr_d;
  logic [GHR_WIDTH-1:0]    w_ghr_shift;
  logic [ENTRIES_LOG2-1:0] w_ghr_ext;

  if (GHR_WIDTH == 1) begin : g_ghr_one
    assign w_ghr_shift = pc_src_res_e_i;
  end else begin : g_ghr_wide
    assign w_ghr_shift = {ghr_q[GHR_WIDTH-2:0], pc_src_res_e_i};
  end

  // History only advances on resolution, never on prediction.
  always_comb begin
    ghr_d = ghr_q;
    if (branch_op_e_i) begin
      ghr_d = w_ghr_shift;
    end
  end

  always_comb begin
    w_ghr_ext                = '0;
    w_ghr_ext[GHR_WIDTH-1:0] = ghr_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign w_idx_f = w_pc_idx ^ w_ghr_ext;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (GHR_WIDTH != 0);
  assign w_idx_f      = w_pc_idx;
`endif

  // Counter array; only the entry addressed by the E-stage index trains.
  for (genvar i = 0; i < c_entries; i++) begin : g_entry
    assign w_enable[i] = branch_op_e_i && (de_idx_q == ENTRIES_LOG2'(i));

    local_predictor u_local_predictor (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .enable_i       (w_enable[i]),
      .pc_src_res_e_i (pc_src_res_e_i),
      .pc_src_pred_o  (w_pred_vec[i])
    );
  end

  // Reads the registered counter, so a same-cycle update is not visible.
  assign pc_src_pred_f_o = w_pred_vec[w_idx_f];

  always_comb begin
    fd_idx_d  = fd_idx_q;
    fd_pred_d = fd_pred_q;
    if (flush_d_i) begin
      fd_idx_d  = '0;
      fd_pred_d = 1'b0;
    end else if (!stall_d_i) begin
      fd_idx_d  = w_idx_f;
      fd_pred_d = pc_src_pred_f_o;
    end
  end

  always_comb begin
    de_idx_d  = fd_idx_q;
    de_pred_d = fd_pred_q;
    if (flush_e_i) begin
      de_idx_d  = '0;
      de_pred_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fd_idx_q  <= '0;
      fd_pred_q <= 1'b0;
      de_idx_q  <= '0;
      de_pred_q <= 1'b0;
    end else begin
      fd_idx_q  <= fd_idx_d;
      fd_pred_q <= fd_pred_d;
      de_idx_q  <= de_idx_d;
      de_pred_q <= de_pred_d;
    end
  end

  assign pc_src_pred_e_o = de_pred_q;
  assign mispredict_e_o  = branch_op_e_i & (de_pred_q != pc_src_res_e_i);

endmodule
`default_nettype wire

// File: tb/tb_branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_history_table
//  Purpose  : Directed testbench for branch_history_table. Stimulus pushes
//             hand-computed expectations into a queue; a monitor on the
//             falling clock edge pops and compares them against the outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_history_table;

  logic        clk_i;
  logic        reset_i;
  logic [31:0] pc_f_i;
  logic        pc_src_pred_f_o;
  logic        stall_d_i;
  logic        flush_d_i;
  logic        flush_e_i;
  logic        branch_op_e_i;
  logic        pc_src_res_e_i;
  logic        pc_src_pred_e_o;
  logic        mispredict_e_o;

  localparam int c_sel_pf = 0;
  localparam int c_sel_pe = 1;
  localparam int c_sel_mp = 2;

  typedef struct {
    string name;
    int    sel;
    logic  val;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  branch_history_table dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .pc_f_i          (pc_f_i),
    .pc_src_pred_f_o (pc_src_pred_f_o),
    .stall_d_i       (stall_d_i),
    .flush_d_i       (flush_d_i),
    .flush_e_i       (flush_e_i),
    .branch_op_e_i   (branch_op_e_i),
    .pc_src_res_e_i  (pc_src_res_e_i),
    .pc_src_pred_e_o (pc_src_pred_e_o),
    .mispredict_e_o  (mispredict_e_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Monitor: compare every queued expectation against the current outputs.
  initial begin
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk_i);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic act;
        e = exp_q.pop_front();
        case (e.sel)
          c_sel_pf: act = pc_src_pred_f_o;
          c_sel_pe: act = pc_src_pred_e_o;
          default:  act = mispredict_e_o;
        endcase
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%b expected=%b (t=%0t)", e.name, act, e.val, $time);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int sel, input logic val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] pc, input logic br, input logic res,
                       input logic sd, input logic fdl, input logic fe);
    pc_f_i         = pc;
    branch_op_e_i  = br;
    pc_src_res_e_i = res;
    stall_d_i      = sd;
    flush_d_i      = fdl;
    flush_e_i      = fe;
  endtask

  // Advance one clock, then apply the next cycle's inputs.
  task automatic cyc(input logic [31:0] pc, input logic br, input logic res,
                     input logic sd, input logic fdl, input logic fe);
    @(posedge clk_i);
    #1;
    drive(pc, br, res, sd, fdl, fe);
  endtask

  initial begin
    reset_i = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

`ifdef BHT_GSHARE_EN
    drive(32'h0, 0, 0, 0, 0, 0);
    expect_out("rst_pred_f", c_sel_pf, 1'b0);
    cyc(32'h0, 1, 1, 0, 0, 0);                 // ctr0 -> WT, GHR=1
    cyc(32'h0, 1, 0, 0, 0, 0);                 // ctr0 -> WU, GHR=10
    cyc(32'h0, 1, 1, 0, 0, 0);                 // ctr0 -> WT, GHR=101
    expect_out("gs_misp", c_sel_mp, 1'b1);
    cyc(32'h14, 0, 0, 0, 0, 0);                // 5 ^ 5 = idx 0
    expect_out("gs_idx0_pred", c_sel_pf, 1'b1);
    cyc(32'h0, 0, 0, 0, 0, 0);                 // 0 ^ 5 = idx 5
    expect_out("gs_idx5_pred", c_sel_pf, 1'b0);
`else
    // A: reset state
    drive(32'h14, 0, 0, 0, 0, 0);
    expect_out("rst_pred_f", c_sel_pf, 1'b0);
    expect_out("rst_pred_e", c_sel_pe, 1'b0);
    expect_out("rst_misp",   c_sel_mp, 1'b0);
    // B: taken branch at idx_e=0 against reset prediction 0
    cyc(32'h14, 1, 1, 0, 0, 0);
    expect_out("rst_misp_taken", c_sel_mp, 1'b1);
    // C: idx_e=5, collision with F lookup at idx 5
    cyc(32'h14, 1, 1, 0, 0, 0);
    expect_out("collide_pre", c_sel_pf, 1'b0);
    expect_out("misp_c",      c_sel_mp, 1'b1);
    // D..E: climb to ST
    cyc(32'h14, 1, 1, 0, 0, 0);
    expect_out("collide_post", c_sel_pf, 1'b1);
    expect_out("misp_d",       c_sel_mp, 1'b1);
    cyc(32'h14, 1, 1, 0, 0, 0);
    expect_out("train_st", c_sel_pf, 1'b1);
    // F..G: two not-taken updates, ST -> WT -> WU
    cyc(32'h14, 1, 0, 0, 0, 0);
    expect_out("sat_st",  c_sel_pf, 1'b1);
    expect_out("pred_e_f", c_sel_pe, 1'b1);
    expect_out("misp_f",  c_sel_mp, 1'b1);
    cyc(32'h14, 1, 0, 0, 0, 0);
    expect_out("wt_pred", c_sel_pf, 1'b1);
    cyc(32'h14, 0, 0, 0, 0, 0);
    expect_out("wu_pred",  c_sel_pf, 1'b0);
    expect_out("pred_e_h", c_sel_pe, 1'b1);
    expect_out("no_branch_misp", c_sel_mp, 1'b0);
    // I: correct prediction, retrain idx 5 to WT
    cyc(32'h14, 1, 1, 0, 0, 0);
    expect_out("correct_misp", c_sel_mp, 1'b0);
    cyc(32'h14, 0, 0, 0, 0, 0);
    expect_out("retrain_pred", c_sel_pf, 1'b1);
    // K..M: stall holds the idx-5 prediction while F moves to idx 6
    cyc(32'h18, 0, 0, 1, 0, 0);
    expect_out("stall_k", c_sel_pe, 1'b0);
    cyc(32'h18, 0, 0, 1, 0, 0);
    expect_out("stall_l", c_sel_pe, 1'b1);
    cyc(32'h18, 0, 0, 1, 0, 0);
    expect_out("stall_m", c_sel_pe, 1'b1);
    cyc(32'h18, 0, 0, 0, 0, 0);
    expect_out("stall_n", c_sel_pe, 1'b1);
    cyc(32'h18, 0, 0, 0, 0, 0);
    expect_out("stall_o", c_sel_pe, 1'b1);
    cyc(32'h14, 0, 0, 0, 0, 0);
    expect_out("stall_p", c_sel_pe, 1'b0);
    cyc(32'h14, 0, 0, 0, 0, 0);
    // R..S: flush_e clears the D->E register
    cyc(32'h14, 0, 0, 0, 0, 1);
    expect_out("pre_flush_e", c_sel_pe, 1'b1);
    cyc(32'h14, 0, 0, 0, 0, 0);
    expect_out("flush_e", c_sel_pe, 1'b0);
    // T..V: flush_d clears the F->D register
    cyc(32'h14, 0, 0, 0, 1, 0);
    expect_out("pre_flush_d", c_sel_pe, 1'b1);
    cyc(32'h14, 0, 0, 0, 0, 0);
    expect_out("flush_d_u", c_sel_pe, 1'b1);
    cyc(32'h14, 0, 0, 0, 0, 0);
    expect_out("flush_d_v", c_sel_pe, 1'b0);
    // W..Y: flush_d wins over stall_d
    cyc(32'h14, 0, 0, 1, 1, 0);
    cyc(32'h14, 0, 0, 0, 0, 0);
    expect_out("prio_x", c_sel_pe, 1'b1);
    cyc(32'h14, 0, 0, 0, 0, 0);
    expect_out("prio_y", c_sel_pe, 1'b0);
    // Z: asynchronous reset mid-cycle with trained counters
    cyc(32'h14, 1, 1, 0, 0, 0);
    #2;
    reset_i = 1'b1;
    expect_out("async_pred_f", c_sel_pf, 1'b0);
    expect_out("async_pred_e", c_sel_pe, 1'b0);
    expect_out("async_misp",   c_sel_mp, 1'b1);
    cyc(32'h14, 0, 0, 0, 0, 0);
    reset_i = 1'b0;
    expect_out("post_rst_idx5", c_sel_pf, 1'b0);
    cyc(32'h0, 0, 0, 0, 0, 0);
    expect_out("post_rst_idx0", c_sel_pf, 1'b0);
    expect_out("post_rst_pe",   c_sel_pe, 1'b0);
`endif

    @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
